// File: rtl/rsa_seq_if.sv
// Bundle of the sequencer's host request/response signals and its two engine
// ports (shared Montgomery product, exponent engine).
//
// Handshake semantics: every *_start is a one-cycle launch pulse whose
// operands stay stable until the matching done. Every *_stop (and the host
// side stop) is treated as done only on its rising edge. The level is never
// used, so a stop left high from an earlier run cannot complete a new one.
interface rsa_seq_if #(
  parameter int BITLEN     = 1024,
  parameter int LOG_BITLEN = 10
);
  // host side
  logic                  start;
  logic [BITLEN-1:0]     msg;
  logic [BITLEN-1:0]     e;
  logic [BITLEN-1:0]     n;
  logic [BITLEN-1:0]     r2;
  logic [BITLEN-1:0]     r_mod_n;
  logic                  busy;
  logic                  stop;
  logic [BITLEN-1:0]     result;
  // Montgomery product engine
  logic                  mp_start;
  logic [BITLEN-1:0]     mp_A;
  logic [BITLEN-1:0]     mp_B;
  logic [BITLEN-1:0]     mp_M;
  logic                  mp_stop;
  logic [BITLEN-1:0]     mp_P;
  // exponent engine
  logic                  exp_start;
  logic [BITLEN-1:0]     exp_M_bar;
  logic [BITLEN-1:0]     exp_x_bar;
  logic [BITLEN-1:0]     exp_n;
  logic [LOG_BITLEN-1:0] exp_e_idx;
  logic                  exp_stop;
  logic [BITLEN-1:0]     exp_ans;

  // host plus engines
  modport master (
    output start, msg, e, n, r2, r_mod_n,
    input  busy, stop, result,
    input  mp_start, mp_A, mp_B, mp_M,
    output mp_stop, mp_P,
    input  exp_start, exp_M_bar, exp_x_bar, exp_n, exp_e_idx,
    output exp_stop, exp_ans
  );

  // the sequencer
  modport slave (
    input  start, msg, e, n, r2, r_mod_n,
    output busy, stop, result,
    output mp_start, mp_A, mp_B, mp_M,
    input  mp_stop, mp_P,
    output exp_start, exp_M_bar, exp_x_bar, exp_n, exp_e_idx,
    input  exp_stop, exp_ans
  );
endinterface

// File: rtl/rsa_seq.sv
// RSA modular exponentiation sequencer: scans e for its MSB, maps msg into
// the Montgomery domain, runs the exponent engine, then maps the result back.
// No arithmetic here; the product and exponent engines do the work.
module rsa_seq #(
  parameter int BITLEN     = 1024,
  parameter int LOG_BITLEN = 10
) (
  input  logic       clk,
  input  logic       rst,
  rsa_seq_if.slave   bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_PRE  = 3'd2,
    S_EXP  = 3'd3,
    S_POST = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  first_q;    // first cycle in current state
  logic [BITLEN-1:0]     msg_q, e_q, n_q, r2_q, rmn_q;
  logic [BITLEN-1:0]     m_bar_q, x_bar_q, result_q;
  logic [LOG_BITLEN-1:0] idx_q;      // scan index; holds the MSB after SCAN
  logic                  mp_prev, exp_prev;
  logic                  mp_take, exp_take;

  // A done edge only counts after the launch cycle, so an edge lining up
  // with our own start pulse belongs to an earlier request.
  assign mp_take  = bus.mp_stop  & ~mp_prev  & ~first_q;
  assign exp_take = bus.exp_stop & ~exp_prev & ~first_q;

  // Edge-detect history follows the raw levels every cycle, reset included,
  // so a level already high at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    mp_prev  <= bus.mp_stop;
    exp_prev <= bus.exp_stop;
  end

  // State register plus first-cycle marker used for the launch pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      first_q <= (state_nxt != state);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_SCAN;
      S_SCAN: begin
        if (e_q[idx_q])        state_nxt = S_PRE;
        else if (idx_q == '0)  state_nxt = S_DONE;
      end
      // e=1 skips EXP: the engine cannot take e_idx=0.
      S_PRE:  if (mp_take)  state_nxt = (idx_q == '0) ? S_POST : S_EXP;
      S_EXP:  if (exp_take) state_nxt = S_POST;
      S_POST: if (mp_take)  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, MSB scan and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q    <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r2_q     <= '0;
      rmn_q    <= '0;
      m_bar_q  <= '0;
      x_bar_q  <= '0;
      result_q <= '0;
      idx_q    <= LOG_BITLEN'(BITLEN - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            msg_q <= bus.msg;
            e_q   <= bus.e;
            n_q   <= bus.n;
            r2_q  <= bus.r2;
            rmn_q <= bus.r_mod_n;
            idx_q <= LOG_BITLEN'(BITLEN - 1);
          end
        end
        S_SCAN: begin
          if (!e_q[idx_q]) begin
            if (idx_q == '0) result_q <= BITLEN'(1);  // x^0 = 1
            else             idx_q    <= idx_q - LOG_BITLEN'(1);
          end
        end
        S_PRE: begin
          if (mp_take) begin
            m_bar_q <= bus.mp_P;
            if (idx_q == '0) x_bar_q <= bus.mp_P;
          end
        end
        S_EXP:  if (exp_take) x_bar_q  <= bus.exp_ans;
        S_POST: if (mp_take)  result_q <= bus.mp_P;
        default: ;
      endcase
    end
  end

  // Outputs: status, launch pulses and engine operands from latched state.
  always_comb begin
    bus.busy      = (state == S_SCAN) || (state == S_PRE) ||
                    (state == S_EXP)  || (state == S_POST);
    bus.stop      = (state == S_DONE);
    bus.result    = result_q;
    bus.mp_start  = first_q && ((state == S_PRE) || (state == S_POST));
    bus.mp_A      = (state == S_POST) ? x_bar_q : msg_q;
    bus.mp_B      = (state == S_POST) ? BITLEN'(1) : r2_q;
    bus.mp_M      = n_q;
    bus.exp_start = first_q && (state == S_EXP);
    bus.exp_M_bar = m_bar_q;
    bus.exp_x_bar = rmn_q;
    bus.exp_n     = n_q;
    bus.exp_e_idx = idx_q;
    dbg_state     = state;
  end

endmodule

// File: tb/tb_rsa_seq.sv
// Bench for rsa_seq at BITLEN=16: behavioural product/exponent engines,
// directed vectors, scoreboard queue popped by a monitor on each stop pulse.
module tb_rsa_seq;
  localparam int W  = 16;
  localparam int LW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_seq_if #(.BITLEN(W), .LOG_BITLEN(LW)) bus ();
  logic [2:0] dbg_state;

  rsa_seq #(.BITLEN(W), .LOG_BITLEN(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int mp_cnt, exp_cnt, scan_cnt, stop_cnt;
  logic [W-1:0] eng_e;       // exponent the engine model works with
  logic abort_eng;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Montgomery product a*b*2^-W mod m
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [47:0] t;
    t = 48'(a) * 48'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + 48'(m);
      t = t >> 1;
    end
    if (t >= 48'(m)) t = t - 48'(m);
    return t[W-1:0];
  endfunction

  // product engine model: drops mp_stop at launch, raises it with P later
  initial begin : mp_engine
    logic [W-1:0] a, b, m;
    bus.mp_stop = 1'b0;
    bus.mp_P    = '0;
    forever begin
      @(negedge clk);
      if (bus.mp_start === 1'b1) begin
        a = bus.mp_A; b = bus.mp_B; m = bus.mp_M;
        bus.mp_stop = 1'b0;
        repeat (3) @(negedge clk);
        bus.mp_P    = mont(a, b, m);
        bus.mp_stop = 1'b1;
      end
    end
  end

  // exponent engine model: left-to-right square-and-multiply in Montgomery form
  initial begin : exp_engine
    logic [W-1:0] mb, x, m;
    logic [LW-1:0] idx;
    logic ok;
    bus.exp_stop = 1'b0;
    bus.exp_ans  = '0;
    forever begin
      @(negedge clk);
      if (bus.exp_start === 1'b1) begin
        mb = bus.exp_M_bar; x = bus.exp_x_bar; m = bus.exp_n; idx = bus.exp_e_idx;
        bus.exp_stop = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (abort_eng) begin ok = 1'b0; break; end
        end
        if (ok) begin
          for (int i = int'(idx); i >= 0; i--) begin
            x = mont(x, x, m);
            if (eng_e[i]) x = mont(x, mb, m);
          end
          bus.exp_ans  = x;
          bus.exp_stop = 1'b1;
        end
      end
    end
  end

  // monitor: pulse counters and scoreboard pop on every stop
  initial begin : monitor
    logic [W-1:0] want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mp_start)       mp_cnt++;
        if (bus.exp_start)      exp_cnt++;
        if (dbg_state == 3'd1)  scan_cnt++;
        if (bus.stop) begin
          stop_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_stop actual=%0d required=no_stop", bus.result);
          end else begin
            want = exp_q.pop_front();
            check("result", 32'(bus.result), 32'(want));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] ee, input logic [W-1:0] nn,
                       input logic [W-1:0] rr2, input logic [W-1:0] rmn,
                       input logic push, input logic [W-1:0] expv);
    @(negedge clk);
    bus.msg = m; bus.e = ee; bus.n = nn; bus.r2 = rr2; bus.r_mod_n = rmn;
    bus.start = 1'b1;
    eng_e = ee;
    mp_cnt = 0; exp_cnt = 0; scan_cnt = 0; stop_cnt = 0;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stop_cnt != 0) break;
    end
    @(negedge clk);
    if (stop_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_stop required=stop", tag);
    end
  endtask

  task automatic wait_exp(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd3) return;
    end
    checks++; errors++;
    $display("FAIL %s_exp_timeout actual=%0d required=3", tag, dbg_state);
  endtask

  task automatic check_counts(input string tag, input int emp, input int eexp, input int escan);
    check({tag, "_mp_starts"},  32'(mp_cnt),   32'(emp));
    check({tag, "_exp_starts"}, 32'(exp_cnt),  32'(eexp));
    check({tag, "_scan_cyc"},   32'(scan_cnt), 32'(escan));
    check({tag, "_stop_cyc"},   32'(stop_cnt), 32'd1);
    check({tag, "_busy_end"},   32'(bus.busy), 32'd0);
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] m, input logic [W-1:0] ee,
                          input logic [W-1:0] expv, input int emp, input int eexp,
                          input int escan);
    // n=143, R=2^16: R mod n = 42, R^2 mod n = 48
    issue(m, ee, 16'd143, 16'd48, 16'd42, 1'b1, expv);
    wait_done(tag);
    check_counts(tag, emp, eexp, escan);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    abort_eng = 1'b0;
    bus.start = 1'b0;
    bus.msg = '0; bus.e = '0; bus.n = '0; bus.r2 = '0; bus.r_mod_n = '0;
    eng_e = '0;
    mp_cnt = 0; exp_cnt = 0; scan_cnt = 0; stop_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_state",     32'(dbg_state),     32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_stop",      32'(bus.stop),      32'd0);
    check("rst_mp_start",  32'(bus.mp_start),  32'd0);
    check("rst_exp_start", 32'(bus.exp_start), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    rst = 1'b0;

    // 7^11 mod 143
    run_case("c1", 16'd7, 16'd11, 16'd106, 2, 1, 13);
    // e=0
    run_case("e0", 16'd7, 16'd0, 16'd1, 0, 0, 16);
    // e=1, PRE starts with mp_stop still high from the last product
    run_case("e1", 16'd5, 16'd1, 16'd5, 2, 0, 16);
    // MSB at the top bit: 2^32768 mod 143 = 2^8 mod 143
    run_case("emsb", 16'd2, 16'h8000, 16'd113, 2, 1, 1);
    // msb=1: 12^2 = 144
    run_case("e2", 16'd12, 16'd2, 16'd1, 2, 1, 15);

    // start re-pulsed with new inputs during EXP
    issue(16'd7, 16'd11, 16'd143, 16'd48, 16'd42, 1'b1, 16'd106);
    wait_exp("restart");
    @(negedge clk);
    bus.msg = 16'd9; bus.e = 16'd3; bus.n = 16'd77; bus.r2 = 16'd5; bus.r_mod_n = 16'd8;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("restart");
    check_counts("restart", 2, 1, 13);

    // reset during EXP with exp_stop held high
    issue(16'd7, 16'd11, 16'd143, 16'd48, 16'd42, 1'b0, '0);
    wait_exp("abort");
    @(negedge clk);
    abort_eng = 1'b1;
    bus.exp_stop = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state",  32'(dbg_state),  32'd0);
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_stop", 32'(stop_cnt), 32'd0);
    abort_eng = 1'b0;
    run_case("after_abort", 16'd7, 16'd11, 16'd106, 2, 1, 13);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
